sram_dma: RTL

Single-channel memory-to-memory copy engine that sits directly upstream of the 65536x32 synchronous SRAM and drives its addr/di/en/we port. It copies a block of words from a source to a destination address range. The CPU keeps priority on the shared SRAM port: the engine stalls on any cycle in which the CPU requests the port. A mux outside this block selects CPU or DMA signals using cpu_req.

---
 rtl/sram_dma_pkg.sv | 9 +
 rtl/sram_dma.sv | 104 ++++++++++
 2 files changed

// File: rtl/sram_dma_pkg.sv
// Shared widths and FSM state type for the SRAM copy engine.
package sram_dma_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

endpackage

// File: rtl/sram_dma.sv
// Single-channel SRAM-to-SRAM copy engine: one word read, captured, then written.
// The CPU has priority on the shared SRAM port, so the engine stalls whenever cpu_req is high.
module sram_dma #(
  parameter int ADDR_W = sram_dma_pkg::ADDR_W,
  parameter int DATA_W = sram_dma_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic              cpu_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_do
);

  import sram_dma_pkg::*;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] src_cur, dst_cur;
  logic [DATA_W-1:0] data_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      data_buf  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              src_cur   <= src;
              dst_cur   <= dst;
              remaining <= len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        CAP: data_buf <= mem_do;
        WR: begin
          // Pointers wrap naturally modulo 2^ADDR_W.
          if (!cpu_req) begin
            src_cur   <= src_cur + ONE;
            dst_cur   <= dst_cur + ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (len != '0)) state_next = RD;
      RD:   if (!cpu_req) state_next = CAP;
      CAP:  state_next = WR;
      WR:   if (!cpu_req) state_next = (remaining == ONE) ? IDLE : RD;
      default: state_next = IDLE;
    endcase
  end

  // SRAM port drive is purely a function of state; a CPU request only gates the enables.
  always_comb begin
    mem_addr = '0;
    mem_di   = '0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      RD: begin
        mem_addr = src_cur;
        mem_en   = !cpu_req;
      end
      WR: begin
        mem_addr = dst_cur;
        mem_di   = data_buf;
        mem_en   = !cpu_req;
        mem_we   = !cpu_req;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
